// File: rtl/seg_display_pkg.sv
// seg_display_pkg: channel word field positions and shared helpers for seg_display_bank.
package seg_display_pkg;
    localparam int VAL_LSB   = 0;
    localparam int BLANK_LSB = 16;
    localparam int BLINK_BIT = 24;

    function automatic logic [31:0] STATUS_OFFSET(input int num_ch);
        return 32'(4 * num_ch);
    endfunction

    function automatic logic [6:0] blank_pattern(input bit active_low);
        return active_low ? 7'h7F : 7'h00;
    endfunction
endpackage

// File: rtl/seven_seg.sv
// seven_seg: hex nibble to active-low segments, seg[6:0] = {g,f,e,d,c,b,a}.
module seven_seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    always_comb begin
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    end
endmodule

// File: rtl/seg_display_bank.sv
// seg_display_bank: bus-mapped bank of multi-digit hex displays with per-digit
// blanking, blink, sticky address-error status and registered readback.
module seg_display_bank
    import seg_display_pkg::*;
#(
    parameter int          NUM_CH     = 3,
    parameter int          DIGITS     = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_00b0,
    parameter int          BLINK_DIV  = 4,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [31:0]                addr,
    input  logic [31:0]                data_in,
    input  logic                       output_write,
    input  logic                       output_read,
    output logic [31:0]                data_out,
    output logic [NUM_CH*DIGITS*7-1:0] seg_out
);
    localparam int NS = NUM_CH * DIGITS;
    localparam logic [31:0] MASK = (((32'd1 << (4 * DIGITS)) - 32'd1) << VAL_LSB)
                                 | (((32'd1 << DIGITS) - 32'd1) << BLANK_LSB)
                                 | (32'd1 << BLINK_BIT);

    logic [31:0]     regs [NUM_CH];
    logic [31:0]     off;
    logic [31:0]     rd_word;
    logic [31:0]     cnt;
    logic            phase;
    logic            err;
    logic            is_ch;
    logic            is_st;
    logic            bad;
    logic [NS*7-1:0] seg_nxt;

    assign off   = addr - BASE_ADDR;
    assign is_ch = addr >= BASE_ADDR && off[1:0] == 2'b00 && off[31:2] < 30'(NUM_CH);
    assign is_st = addr == BASE_ADDR + STATUS_OFFSET(NUM_CH);
    assign bad   = (output_write && !is_ch) || (output_read && !is_ch && !is_st);

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (off[31:2] == 30'(i)) rd_word = regs[i];
    end

    // Decoder output is active-low; invert afterwards for active-high boards.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        for (genvar j = 0; j < DIGITS; j++) begin : g_dig
            logic [6:0] raw;
            seven_seg u_dec (.hex(regs[i][VAL_LSB + 4*j +: 4]), .seg(raw));
            assign seg_nxt[(i*DIGITS + j)*7 +: 7] =
                (regs[i][BLANK_LSB + j] || (regs[i][BLINK_BIT] && phase)) ? blank_pattern(ACTIVE_LOW)
                : ACTIVE_LOW ? raw : ~raw;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) regs[i] <= '0;
            cnt      <= '0;
            phase    <= 1'b0;
            err      <= 1'b0;
            data_out <= '0;
            seg_out  <= {NS{blank_pattern(ACTIVE_LOW)}};
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (output_write && is_ch && off[31:2] == 30'(i)) regs[i] <= data_in & MASK;
            cnt <= (cnt == 32'(BLINK_DIV - 1)) ? '0 : cnt + 32'd1;
            if (cnt == 32'(BLINK_DIV - 1)) phase <= ~phase;
            // A status read clears err, but an error on the same edge wins.
            err <= ((output_read && is_st) ? 1'b0 : err) | bad;
            if (output_read) data_out <= is_ch ? rd_word : is_st ? {31'b0, err} : '0;
            seg_out <= seg_nxt;
        end
    end
endmodule
